// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched PAT_W-bit pattern out
// MSB-first, repeat_n times, with an optional idle gap between repeats.
//
// Ports:
//   clk, rst      clock (rising edge), synchronous active-low reset
//   start         job request, sampled only in IDLE
//   pattern       pattern to send, latched on accept
//   repeat_n      repetition count, latched on accept (0 = empty job)
//   gap           idle cycles between repetitions, latched on accept
//   abort         (only with SEQ_TX_ABORT_EN) truncate a running job
//   data          serial bit, 0 whenever bit_valid is 0
//   bit_valid     data carries a pattern bit
//   frame_end     asserted with the last bit of each repetition
//   busy          job in progress
//   done          one-cycle end-of-job pulse
//
// Optional feature macro: SEQ_TX_ABORT_EN adds the abort input.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
`ifdef SEQ_TX_ABORT_EN
  input  logic             abort,
`endif
  output logic             data,
  output logic             bit_valid,
  output logic             frame_end,
  output logic             busy,
  output logic             done
);

  localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IW-1:0] MSB = IW'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d, idx_m1;
  logic [CNT_W-1:0] rem_q, rem_d, rem_m1;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             data_d, valid_d, fe_d;
  logic             busy_d, done_d;
  logic             abort_i;

`ifdef SEQ_TX_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Outputs are computed for the state being entered, so every
  // output is a flop and the first bit appears one cycle after start.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    gcnt_d  = gcnt_q;
    gap_d   = gap_q;
    pat_d   = pat_q;
    data_d  = 1'b0;
    valid_d = 1'b0;
    fe_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    idx_m1  = idx_q - 1'b1;
    rem_m1  = rem_q - 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (repeat_n != '0) begin
            state_d = SHIFT;
            pat_d   = pattern;
            rem_d   = repeat_n;
            gap_d   = gap;
            idx_d   = MSB;
            data_d  = pattern[PAT_W-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (abort_i) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (idx_q != '0) begin
          idx_d   = idx_m1;
          data_d  = pat_q[idx_m1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          fe_d    = (idx_m1 == '0);
        end else begin
          // bit 0 is on the wire now; close out this repetition
          rem_d = rem_m1;
          if (rem_m1 == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (gap_q == '0) begin
            idx_d   = MSB;
            data_d  = pat_q[PAT_W-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = GAP;
            gcnt_d  = gap_q;
            busy_d  = 1'b1;
          end
        end
      end

      GAP: begin
        if (abort_i) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (gcnt_q == GAP_W'(1)) begin
          state_d = SHIFT;
          gcnt_d  = '0;
          idx_d   = MSB;
          data_d  = pat_q[PAT_W-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
          busy_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rem_q     <= '0;
      gcnt_q    <= '0;
      gap_q     <= '0;
      pat_q     <= '0;
      data      <= 1'b0;
      bit_valid <= 1'b0;
      frame_end <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      gcnt_q    <= gcnt_d;
      gap_q     <= gap_d;
      pat_q     <= pat_d;
      data      <= data_d;
      bit_valid <= valid_d;
      frame_end <= fe_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx.
// Second instance uses CNT_W=4 to cover the maximum repeat count.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] pattern = '0;
  logic [7:0] repeat_n = '0;
  logic [3:0] gap = '0;
  logic       data, bit_valid, frame_end, busy, done;

  logic       start4 = 1'b0;
  logic [3:0] rep4 = '0;
  logic       data4, valid4, fe4, busy4, done4;

`ifdef SEQ_TX_ABORT_EN
  logic       abort = 1'b0;
`endif

  logic [4:0] obs;
  assign obs = {data, bit_valid, frame_end, busy, done};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pattern  (pattern),
    .repeat_n (repeat_n),
    .gap      (gap),
`ifdef SEQ_TX_ABORT_EN
    .abort    (abort),
`endif
    .data     (data),
    .bit_valid(bit_valid),
    .frame_end(frame_end),
    .busy     (busy),
    .done     (done)
  );

  seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_W(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .start    (start4),
    .pattern  (pattern),
    .repeat_n (rep4),
    .gap      (gap),
`ifdef SEQ_TX_ABORT_EN
    .abort    (1'b0),
`endif
    .data     (data4),
    .bit_valid(valid4),
    .frame_end(fe4),
    .busy     (busy4),
    .done     (done4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bit got;
    rst = 1'b0;
    tick;
    tick;
    checks++;
    if (obs !== 5'b00000)
      $display("FAIL reset_init got %b want 00000", obs);
    if (obs !== 5'b00000) errors++;
    rst = 1'b1;
    pattern = 4'b1011;
    repeat_n = 8'd3;
    gap = 4'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL reset_mid %0d got %b want 00000", i, obs);
      end
    end
    rst = 1'b1;
    tick;
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL reset_after got %b want 00000", obs);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (obs !== 5'b11010) begin
      errors++;
      $display("FAIL reset_restart got %b want 11010", obs);
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL reset_job_done got 0 want 1");
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_s;
    logic [7:0] s;
    logic [4:0] ex;
    int hits;
    exp_s = 8'b10111011;
    s = '0;
    pattern = 4'b1011;
    repeat_n = 8'd2;
    gap = 4'd0;
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick;
      start = 1'b0;
      if (c <= 8) begin
        ex = {exp_s[8-c], 1'b1, (c == 4 || c == 8), 1'b1, 1'b0};
        s = {s[6:0], data};
      end else begin
        ex = 5'b00001;
      end
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL b2b cycle %0d got %b want %b", c, obs, ex);
      end
    end
    hits = 0;
    for (int i = 0; i <= 4; i++) begin
      if (s[7-i -: 4] == 4'b1011) hits++;
    end
    checks++;
    if (hits !== 2) begin
      errors++;
      $display("FAIL b2b_detect got %0d want 2", hits);
    end
    tick;
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL b2b_idle got %b want 00000", obs);
    end
  endtask

  task automatic test_gap;
    logic [3:0] p;
    logic [4:0] ex;
    int ph;
    int nbusy;
    p = 4'b1101;
    pattern = p;
    repeat_n = 8'd3;
    gap = 4'd2;
    nbusy = 0;
    start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick;
      start = 1'b0;
      ph = (c - 1) % 6;
      if (c == 17) ex = 5'b00001;
      else if (ph < 4) ex = {p[3-ph], 1'b1, (ph == 3), 1'b1, 1'b0};
      else ex = 5'b00010;
      if (busy) nbusy++;
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL gap cycle %0d got %b want %b", c, obs, ex);
      end
    end
    checks++;
    if (nbusy !== 16) begin
      errors++;
      $display("FAIL gap_busy got %0d want 16", nbusy);
    end
    tick;
  endtask

  task automatic test_zero_max;
    int nv, nf, nd, nb, n1;
    pattern = 4'b1011;
    repeat_n = 8'd0;
    gap = 4'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (obs !== 5'b00001) begin
      errors++;
      $display("FAIL zero_rep got %b want 00001", obs);
    end
    tick;
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL zero_rep_idle got %b want 00000", obs);
    end
    nv = 0; nf = 0; nd = 0; nb = 0; n1 = 0;
    rep4 = 4'd15;
    start4 = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      tick;
      start4 = 1'b0;
      if (valid4) nv++;
      if (fe4) nf++;
      if (done4) nd++;
      if (busy4) nb++;
      if (data4) n1++;
    end
    checks++;
    if (nv !== 60) begin
      errors++;
      $display("FAIL max_valid got %0d want 60", nv);
    end
    checks++;
    if (nf !== 15) begin
      errors++;
      $display("FAIL max_frame_end got %0d want 15", nf);
    end
    checks++;
    if (nd !== 1 || nb !== 60 || n1 !== 45) begin
      errors++;
      $display("FAIL max_misc got done=%0d busy=%0d ones=%0d want 1 60 45",
               nd, nb, n1);
    end
    nv = 0; nd = 0;
    repeat_n = 8'd255;
    start = 1'b1;
    for (int c = 1; c <= 1030; c++) begin
      tick;
      start = 1'b0;
      if (bit_valid) nv++;
      if (done) nd++;
    end
    checks++;
    if (nv !== 1020 || nd !== 1) begin
      errors++;
      $display("FAIL max255 got valid=%0d done=%0d want 1020 1", nv, nd);
    end
  endtask

  task automatic test_ignored_inputs;
    logic [7:0] exp_s;
    logic [4:0] ex;
    bit got;
    exp_s = 8'b10111011;
    pattern = 4'b1011;
    repeat_n = 8'd2;
    gap = 4'd0;
    start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick;
      if (c == 2) begin
        pattern = 4'b0000;
        repeat_n = 8'd5;
        gap = 4'd3;
      end
      if (c <= 8) ex = {exp_s[8-c], 1'b1, (c == 4 || c == 8), 1'b1, 1'b0};
      else if (c == 9) ex = 5'b00001;
      else if (c == 10) ex = 5'b00000;
      else ex = 5'b01010;
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL ignore cycle %0d got %b want %b", c, obs, ex);
      end
    end
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ignore_job2_done got 0 want 1");
    end
    tick;
  endtask

`ifdef SEQ_TX_ABORT_EN
  task automatic test_abort;
    logic [7:0] exp_s;
    logic [4:0] ex;
    int nf, nd;
    bit got;
    exp_s = 8'b10111011;
    pattern = 4'b1011;
    repeat_n = 8'd2;
    gap = 4'd0;
    nf = 0;
    nd = 0;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick;
      start = 1'b0;
      abort = (c == 6);
      if (c <= 6) ex = {exp_s[8-c], 1'b1, (c == 4), 1'b1, 1'b0};
      else if (c == 7) ex = 5'b00001;
      else ex = 5'b00000;
      if (frame_end) nf++;
      if (done) nd++;
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL abort cycle %0d got %b want %b", c, obs, ex);
      end
    end
    checks++;
    if (nf !== 1 || nd !== 1) begin
      errors++;
      $display("FAIL abort_counts got fe=%0d done=%0d want 1 1", nf, nd);
    end
    abort = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (obs !== 5'b11010) begin
      errors++;
      $display("FAIL abort_idle got %b want 11010", obs);
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL abort_idle_done got 0 want 1");
    end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_back_to_back;
    test_gap;
    test_zero_max;
    test_ignored_inputs;
`ifdef SEQ_TX_ABORT_EN
    test_abort;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
